// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central stall/flush controller for the five-stage core.
//
// Each cycle it turns the stage busy signals, the decode load-use hazard
// and the EX branch resolution into per-register hold/bubble controls
// (bit0 PC/F, bit1 D, bit2 E, bit3 M, bit4 W) and the PC redirect.
// A taken branch that arrives while a fetch is outstanding is parked in
// PEND with its target. It is applied once the fetch returns and no
// downstream stall is active, and the returning wrong-path instruction
// is discarded.
//
// Ports:
//   clk            core clock
//   reset          synchronous, active-high
//   if_busy        fetch outstanding, no instruction this cycle
//   mem_busy       M-stage data access not complete
//   ex_busy        multi-cycle EX operation not complete
//   load_use       D-stage instruction depends on a load still in E
//   br_taken       EX resolved a taken branch/jump this cycle
//   br_target      redirect target PC
//   hold[4:0]      register keeps its contents
//   bubble[4:0]    register loads a NOP
//   pc_redirect    PC loads pc_target on this edge
//   pc_target      redirect address (0 when pc_redirect=0)
//   stall_cycles   cycles with any hold bit set   (PIPE_CTRL_PERF_EN)
//   redirect_count number of pc_redirect pulses   (PIPE_CTRL_PERF_EN)
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the two 64-bit
// performance counters. Without it, the counter ports and logic are absent.

module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ex_busy,
    input  logic        load_use,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [4:0]  hold,
    output logic [4:0]  bubble,
    output logic        pc_redirect,
    output logic [63:0] pc_target
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [63:0] stall_cycles,
    output logic [63:0] redirect_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] pend_target;
    logic        enter_pend;
    logic        leave_pend;

    // Priority decode; the first matching condition owns every output.
    always_comb begin
        hold        = 5'b00000;
        bubble      = 5'b00000;
        pc_redirect = 1'b0;
        pc_target   = 64'd0;
        enter_pend  = 1'b0;
        leave_pend  = 1'b0;
        if (reset) begin
            bubble = 5'b11111;
        end else if (mem_busy) begin
            hold   = 5'b01111;
            bubble = 5'b10000;
        end else if (ex_busy) begin
            hold   = 5'b00111;
            bubble = 5'b01000;
        end else if (state == PEND) begin
            // D and E hold only bubbles here, so br_taken/load_use are moot.
            bubble = 5'b00010;
            if (if_busy) begin
                hold = 5'b00001;
            end else begin
                pc_redirect = 1'b1;
                pc_target   = pend_target;
                leave_pend  = 1'b1;
            end
        end else if (br_taken) begin
            bubble = 5'b00110;
            if (if_busy) begin
                // Fetch still in flight: park the target until it returns.
                hold       = 5'b00001;
                enter_pend = 1'b1;
            end else begin
                pc_redirect = 1'b1;
                pc_target   = br_target;
            end
        end else if (load_use) begin
            hold   = 5'b00011;
            bubble = 5'b00100;
        end else if (if_busy) begin
            hold   = 5'b00001;
            bubble = 5'b00010;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pend_target <= 64'd0;
        end else if (enter_pend) begin
            state       <= PEND;
            pend_target <= br_target;
        end else if (leave_pend) begin
            state       <= IDLE;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles   <= 64'd0;
            redirect_count <= 64'd0;
        end else begin
            if (hold != 5'b00000)
                stall_cycles <= stall_cycles + 64'd1;
            if (pc_redirect)
                redirect_count <= redirect_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_busy = 1'b0, mem_busy = 1'b0, ex_busy = 1'b0;
    logic        load_use = 1'b0, br_taken = 1'b0;
    logic [63:0] br_target = 64'd0;
    logic [4:0]  hold, bubble;
    logic        pc_redirect;
    logic [63:0] pc_target;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] stall_cycles, redirect_count;
`endif

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
        .ex_busy(ex_busy), .load_use(load_use), .br_taken(br_taken),
        .br_target(br_target), .hold(hold), .bubble(bubble),
        .pc_redirect(pc_redirect), .pc_target(pc_target)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  hold;
        logic [4:0]  bubble;
        logic        redir;
        logic [63:0] tgt;
        logic [63:0] stalls;
        logic [63:0] redirs;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: a parked redirect, plus counter tallies.
    bit          m_pending = 1'b0;
    logic [63:0] m_ptarget = 64'd0;
    logic [63:0] m_stalls  = 64'd0;
    logic [63:0] m_redirs  = 64'd0;

    // Stall depth k: registers 0..k-1 freeze, register k receives a NOP.
    function automatic void freeze(input int k, output logic [4:0] h,
                                   output logic [4:0] b);
        h = 5'((1 << k) - 1);
        b = 5'(1 << k);
    endfunction

    task automatic drive(input bit r, input bit ifb, input bit memb,
                         input bit exb, input bit lu, input bit bt,
                         input logic [63:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; if_busy = ifb; mem_busy = memb; ex_busy = exb;
        load_use = lu; br_taken = bt; br_target = tgt;
        e.hold = 5'd0; e.bubble = 5'd0; e.redir = 1'b0; e.tgt = 64'd0;
        e.stalls = m_stalls; e.redirs = m_redirs;
        if (r) begin
            e.bubble = 5'b11111;
            m_pending = 1'b0; m_ptarget = 64'd0;
        end else if (memb) freeze(4, e.hold, e.bubble);
        else if (exb)      freeze(3, e.hold, e.bubble);
        else if (m_pending) begin
            // Wrong-path fetch is dropped at D either way.
            if (ifb) freeze(1, e.hold, e.bubble);
            else begin
                e.bubble = 5'b00010; e.redir = 1'b1; e.tgt = m_ptarget;
                m_pending = 1'b0;
            end
        end else if (bt) begin
            e.bubble = 5'b00110;  // squash D and E
            if (ifb) begin
                e.hold = 5'b00001; m_pending = 1'b1; m_ptarget = tgt;
            end else begin
                e.redir = 1'b1; e.tgt = tgt;
            end
        end else if (lu)  freeze(2, e.hold, e.bubble);
        else if (ifb)     freeze(1, e.hold, e.bubble);
        if (r) begin
            m_stalls = 64'd0; m_redirs = 64'd0;
        end else begin
            if (e.hold != 5'd0) m_stalls = m_stalls + 64'd1;
            if (e.redir)        m_redirs = m_redirs + 64'd1;
        end
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: outputs are combinational and presented every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("hold", 64'(hold), 64'(e.hold));
                check("bubble", 64'(bubble), 64'(e.bubble));
                check("pc_redirect", 64'(pc_redirect), 64'(e.redir));
                check("pc_target", pc_target, e.tgt);
                check("hold_and_bubble", 64'(hold & bubble), 64'd0);
`ifdef PIPE_CTRL_PERF_EN
                check("stall_cycles", stall_cycles, e.stalls);
                check("redirect_count", redirect_count, e.redirs);
`endif
            end
        end
    end

    initial begin
        // Reset held two cycles, then released with quiet inputs.
        drive(1, 0, 0, 0, 0, 0, 64'd0);
        drive(1, 0, 0, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // mem_busy with load_use for three cycles.
        repeat (3) drive(0, 0, 1, 0, 1, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // Redirect with no fetch in flight.
        drive(0, 0, 0, 0, 0, 1, 64'h8000_1000);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // Redirect with fetch in flight for four cycles.
        drive(0, 1, 0, 0, 0, 1, 64'h8000_2000);
        repeat (3) drive(0, 1, 0, 0, 1, 1, 64'h1234);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // PEND frozen by mem_busy while the fetch returns.
        drive(0, 1, 0, 0, 0, 1, 64'h8000_3000);
        repeat (2) drive(0, 0, 1, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 1, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // Branch and load_use together.
        drive(0, 0, 0, 0, 1, 1, 64'h8000_4000);
        // Reset in PEND drops the pending redirect.
        drive(0, 1, 0, 0, 0, 1, 64'h8000_5000);
        drive(1, 1, 0, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        drive(0, 0, 0, 0, 0, 0, 64'd0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(99) < 2), ($urandom_range(99) < 45),
                  ($urandom_range(99) < 12), ($urandom_range(99) < 12),
                  ($urandom_range(99) < 20), ($urandom_range(99) < 25),
                  {$urandom, $urandom});
        end
        repeat (3) @(posedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
